// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock level-reporting FIFO.
package sync_fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    // Number of storage entries for a given address width.
    function automatic int fifo_depth(input int asize);
        return 32'sd1 << asize;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_lvl: one write port and one registered read
// port. The array itself is not reset; only the read register is.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [DSIZE-1:0] rdata_q;

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port: load on re, hold otherwise, clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= {DSIZE{1'b0}};
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a registered read port with valid.
// Optional build macro SYNC_FIFO_PEAK_EN adds a peak_level high-water mark.
module sync_fifo_lvl
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    input  logic [ASIZE:0]   af_thresh,
    input  logic [ASIZE:0]   ae_thresh,
    output logic [ASIZE:0]   level,
    output logic             ovf,
    output logic             udf,
`ifdef SYNC_FIFO_PEAK_EN
    output logic [ASIZE:0]   peak_level,
`endif
    input  logic             err_clr
);

    localparam int             DEPTH   = fifo_depth(ASIZE);
    localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] ONE_L   = (ASIZE+1)'(1);

    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic [ASIZE-1:0] raddr_q, raddr_d;
    logic [ASIZE:0]   level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rvalid_q;
    logic             wfull_s, rempty_s;
    logic             wr_ok_s, rd_ok_s;

    // Status flags are straight decodes of the level register.
    always_comb begin
        wfull_s       = (level_q == DEPTH_L);
        rempty_s      = (level_q == {(ASIZE+1){1'b0}});
        walmost_full  = (level_q >= af_thresh);
        ralmost_empty = (level_q <= ae_thresh);
    end

    // Accept decisions, pointer/level next state and sticky error next state.
    always_comb begin
        wr_ok_s = winc & ~wfull_s;
        rd_ok_s = rinc & ~rempty_s;

        if (wr_ok_s) begin
            waddr_d = waddr_q + {{(ASIZE-1){1'b0}}, 1'b1};
        end else begin
            waddr_d = waddr_q;
        end

        if (rd_ok_s) begin
            raddr_d = raddr_q + {{(ASIZE-1){1'b0}}, 1'b1};
        end else begin
            raddr_d = raddr_q;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   level_d = level_q + ONE_L;
            2'b01:   level_d = level_q - ONE_L;
            default: level_d = level_q;
        endcase

        // A set condition outranks a simultaneous clear.
        if (winc & wfull_s) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (rinc & rempty_s) begin
            udf_d = 1'b1;
        end else if (err_clr) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Pointer, level, error and read-valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waddr_q  <= {ASIZE{1'b0}};
            raddr_q  <= {ASIZE{1'b0}};
            level_q  <= {(ASIZE+1){1'b0}};
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rvalid_q <= rd_ok_s;
        end
    end

    // Memory accesses are suppressed during reset so reset-cycle requests vanish.
    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok_s & rst_n),
        .waddr (waddr_q),
        .wdata (wdata),
        .re    (rd_ok_s & rst_n),
        .raddr (raddr_q),
        .rdata (rdata)
    );

`ifdef SYNC_FIFO_PEAK_EN
    logic [ASIZE:0] peak_q, peak_d;

    // High-water mark follows the level as it becomes visible; clear restarts it.
    always_comb begin
        if (err_clr) begin
            peak_d = level_d;
        end else if (level_d > peak_q) begin
            peak_d = level_d;
        end else begin
            peak_d = peak_q;
        end
    end

    // Peak register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_q <= {(ASIZE+1){1'b0}};
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`endif

    assign wfull  = wfull_s;
    assign rempty = rempty_s;
    assign level  = level_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Self-checking bench for sync_fifo_lvl: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_sync_fifo_lvl;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   af_thresh;
    logic [ASIZE:0]   ae_thresh;
    logic [ASIZE:0]   level;
    logic             ovf;
    logic             udf;
    logic             err_clr;
`ifdef SYNC_FIFO_PEAK_EN
    logic [ASIZE:0]   peak_level;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [DSIZE-1:0] m_q[$];
    logic             m_ovf, m_udf, m_rvalid;
    logic [DSIZE-1:0] m_rdata;
    int               m_peak;
    bit               m_live = 1'b0;

    sync_fifo_lvl #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wdata         (wdata),
        .winc          (winc),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .rinc          (rinc),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .af_thresh     (af_thresh),
        .ae_thresh     (ae_thresh),
        .level         (level),
        .ovf           (ovf),
        .udf           (udf),
`ifdef SYNC_FIFO_PEAK_EN
        .peak_level    (peak_level),
`endif
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance on every rising edge from the applied inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0;
            m_rdata = '0; m_peak = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            bit full, empty;
            full  = (m_q.size() == DEPTH);
            empty = (m_q.size() == 0);
            if (rinc && !empty) begin
                m_rdata  = m_q.pop_front();
                m_rvalid = 1'b1;
            end else begin
                m_rvalid = 1'b0;
            end
            if (winc && !full) m_q.push_back(wdata);
            if (winc && full) m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
            if (rinc && empty) m_udf = 1'b1;
            else if (err_clr) m_udf = 1'b0;
            if (err_clr || m_q.size() > m_peak) m_peak = m_q.size();
        end
    end

    // Compare process: all outputs against the model, once per cycle.
    always @(negedge clk) begin
        if (m_live) begin
            check("level",         int'(level),         m_q.size());
            check("wfull",         int'(wfull),         int'(m_q.size() == DEPTH));
            check("rempty",        int'(rempty),        int'(m_q.size() == 0));
            check("walmost_full",  int'(walmost_full),  int'(m_q.size() >= int'(af_thresh)));
            check("ralmost_empty", int'(ralmost_empty), int'(m_q.size() <= int'(ae_thresh)));
            check("rvalid",        int'(rvalid),        int'(m_rvalid));
            check("rdata",         int'(rdata),         int'(m_rdata));
            check("ovf",           int'(ovf),           int'(m_ovf));
            check("udf",           int'(udf),           int'(m_udf));
`ifdef SYNC_FIFO_PEAK_EN
            check("peak_level",    int'(peak_level),    m_peak);
`endif
        end
    end

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input bit w, input int wd, input bit r, input bit clr, input bit rst);
        @(negedge clk);
        winc    = w;
        wdata   = wd[DSIZE-1:0];
        rinc    = r;
        err_clr = clr;
        rst_n   = ~rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = '0;
        af_thresh = 5'd14; ae_thresh = 5'd2;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("reset_level",  int'(level),  0);
        check("reset_rempty", int'(rempty), 1);
        check("reset_rvalid", int'(rvalid), 0);
        check("reset_rdata",  int'(rdata),  0);

        // Scenario 1: fill then drain in order
        for (int i = 0; i < 16; i++) begin
            step(1, i, 0, 0, 0);
            if (i == 12) check("s1_af_at13", int'(walmost_full), 0);
            if (i == 13) check("s1_af_at14", int'(walmost_full), 1);
            if (i == 14) check("s1_full_at15", int'(wfull), 0);
        end
        check("s1_full",  int'(wfull), 1);
        check("s1_level", int'(level), 16);
        check("s1_ovf",   int'(ovf),   0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 0);
            check("s1_rvalid", int'(rvalid), 1);
            check("s1_rdata",  int'(rdata),  i);
        end
        step(0, 0, 0, 0, 0);
        check("s1_rvalid_idle", int'(rvalid), 0);
        check("s1_rdata_hold",  int'(rdata),  15);
        check("s1_rempty",      int'(rempty), 1);
        check("s1_ae",          int'(ralmost_empty), 1);

        // Scenario 2: write rejected while full even with a read
        for (int i = 0; i < 16; i++) step(1, i, 0, 0, 0);
        step(1, 8'hEE, 1, 0, 0);
        check("s2_ovf",   int'(ovf),   1);
        check("s2_level", int'(level), 15);
        check("s2_rdata", int'(rdata), 0);

        // Scenario 3: read rejected while empty even with a write
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
        check("s3_last", int'(rdata), 15);
        step(1, 8'hA5, 1, 0, 0);
        check("s3_udf",    int'(udf),    1);
        check("s3_level",  int'(level),  1);
        check("s3_rvalid", int'(rvalid), 0);
        step(0, 0, 1, 0, 0);
        check("s3_rvalid2", int'(rvalid), 1);
        check("s3_rdata",   int'(rdata),  8'hA5);

        // Scenario 5: set beats clear, clear alone clears
        for (int i = 0; i < 16; i++) step(1, 8'h20 + i, 0, 0, 0);
        step(1, 8'hFF, 0, 1, 0);
        check("s5_ovf_kept", int'(ovf), 1);
        check("s5_udf_clr",  int'(udf), 0);
        step(0, 0, 0, 1, 0);
        check("s5_ovf_clr",  int'(ovf), 0);

        // Scenario 4: level held at 8 with simultaneous traffic across the wrap
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
        check("s4_level8", int'(level), 8);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'h40 + i, 1, 0, 0);
            check("s4_level", int'(level), 8);
            if (i < 8) check("s4_order_old", int'(rdata), 8'h28 + i);
            else       check("s4_order_new", int'(rdata), 8'h40 + i - 8);
        end
        check("s4_ovf", int'(ovf), 0);
        check("s4_udf", int'(udf), 0);

        // Scenario 6: reset mid-operation with a write request
        step(1, 8'h77, 0, 0, 0);
        check("s6_level9", int'(level), 9);
        step(1, 8'h78, 0, 0, 1);
        check("s6_level",  int'(level),  0);
        check("s6_rempty", int'(rempty), 1);
        check("s6_rvalid", int'(rvalid), 0);
        check("s6_ovf",    int'(ovf),    0);
`ifdef SYNC_FIFO_PEAK_EN
        check("s6_peak0",  int'(peak_level), 0);
        for (int i = 0; i < 16; i++) step(1, i, 0, 0, 0);
        check("s6_peak16", int'(peak_level), 16);
`endif

        // Threshold edge cases
        af_thresh = 5'd0; ae_thresh = 5'd16;
        step(0, 0, 0, 0, 0);
        check("th_af0",    int'(walmost_full),  1);
        check("th_ae16",   int'(ralmost_empty), 1);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int mode;
            if (c % 500 == 0) begin
                af_thresh = 5'($urandom_range(0, 18));
                ae_thresh = 5'($urandom_range(0, 18));
            end
            mode = (c / 400) % 3;
            step($urandom_range(0, 99) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50)),
                 int'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < (mode == 0 ? 30 : (mode == 1 ? 70 : 50)),
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 999) < 4);
        end
        step(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_lvl.md
Name: sync_fifo_lvl

Overview:
Single-clock, parametrised successor to the team's dual-clock FIFO, used wherever producer and consumer share one clock.
- Adds a fill-level output and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags.
- Read data is registered, with a valid strobe.
- Sits between same-clock datapath stages as an elastic buffer with back-pressure.

Parameters:
DSIZE, 8, data word width in bits
ASIZE, 4, address bits; DEPTH = 1<<ASIZE entries

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  reset; synchronous, active-low
wdata  input  DSIZE  write data
winc  input  1  write request
wfull  output  1  FIFO holds DEPTH entries
walmost_full  output  1  level >= af_thresh
rinc  input  1  read request
rdata  output  DSIZE  registered read data
rvalid  output  1  rdata holds a newly popped word this cycle
rempty  output  1  FIFO holds 0 entries
ralmost_empty  output  1  level <= ae_thresh
af_thresh  input  ASIZE+1  almost-full threshold; quasi-static
ae_thresh  input  ASIZE+1  almost-empty threshold; quasi-static
level  output  ASIZE+1  current occupancy, 0..DEPTH
ovf  output  1  sticky overflow flag
udf  output  1  sticky underflow flag
err_clr  input  1  clears ovf and udf

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low. It is sampled only on posedge clk.
- Reset values while rst_n=0 at a clock edge:
  - waddr=0, raddr=0, level=0
  - rempty=1, wfull=0, rvalid=0, rdata=0, ovf=0, udf=0
  - Memory contents are not reset.
- Reset mid-operation discards all contents. Requests in the reset cycle are ignored and do not set ovf/udf.
- Write acceptance: wr_ok = winc & ~wfull. An accepted write stores mem[waddr] <= wdata and waddr increments, wrapping DEPTH-1 -> 0.
- Read acceptance: rd_ok = rinc & ~rempty. An accepted read registers rdata <= mem[raddr] and raddr increments with wrap.
  - rvalid=1 in the cycle after rd_ok; otherwise rvalid=0.
  - rdata holds its last value when no read is accepted.
- Read latency is 1 clk from rinc to rvalid/rdata.
- Write-to-read latency: a word written in cycle N first drives rempty=0 in cycle N+1. The earliest rvalid is N+2.
- Level update:
  - +1 on wr_ok only; -1 on rd_ok only.
  - Unchanged when both are accepted or neither is.
  - Width is ASIZE+1; it never exceeds DEPTH or goes below 0.
- Flags are combinational decodes of the level register, with no extra latency:
  - wfull = (level==DEPTH)
  - rempty = (level==0)
  - walmost_full = (level >= af_thresh)
  - ralmost_empty = (level <= ae_thresh)
  - Comparisons are unsigned.
- Full boundary: winc while wfull is rejected even if rinc is accepted in the same cycle. No write-through.
- Empty boundary: rinc while rempty is rejected even if winc is accepted in the same cycle. No bypass.
- Overflow: ovf sets on (winc & wfull).
- Underflow: udf sets on (rinc & rempty).
- Error clear: err_clr=1 clears both flags next cycle. If a set condition and err_clr occur in the same cycle, the set wins.
- Threshold edge cases: af_thresh=0 gives walmost_full constantly 1. ae_thresh >= DEPTH gives ralmost_empty constantly 1. Both are legal.
- There is no state machine beyond the pointer/level counters. Rejected requests have no side effect except setting ovf/udf.

Optional Feature:
Macro SYNC_FIFO_PEAK_EN.
- Defined:
  - Adds output peak_level [ASIZE:0], the high-water mark of level since the last reset or err_clr.
  - Updates to the next-cycle level when that exceeds the current peak, so it is coincident with level.
  - Reset value is 0. err_clr loads the current level.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - default DSIZE/ASIZE localparams
  - the function fifo_depth(asize) = 1<<asize
- Sub-module sync_fifo_mem: DSIZE x DEPTH array with a write port (we, waddr, wdata) and a registered read port (re, raddr, rdata). rdata is reset to 0 by rst_n and held when re=0.
- Pointers, level, flags and error logic stay in sync_fifo_lvl.

Test Plan:
All scenarios use DSIZE=8, ASIZE=4 (DEPTH=16), af_thresh=14, ae_thresh=2.
1. Reset, then 16 writes 0x00..0x0F: walmost_full=1 at level=14, wfull=1 at level=16, ovf=0. Then 16 reads: rdata 0x00..0x0F with rvalid one cycle after each rinc; rempty=1 and ralmost_empty=1 at the end.
2. Full, then winc=1 with rinc=1 for one cycle: the write is rejected, ovf=1, level=15, the popped word is 0x00.
3. Empty, then rinc=1 with winc=1 (wdata=0xA5): the read is rejected, udf=1, level=1. The next rinc returns 0xA5 with rvalid=1.
4. Level=8, then 20 cycles of winc=rinc=1 with an incrementing pattern: level stays 8, pointers wrap past 15->0, and output order is preserved with no ovf/udf.
5. ovf=1 and udf=1, then err_clr=1 in the same cycle as another overflow: ovf stays 1 and udf clears. err_clr alone then clears ovf.
6. Level=9, then rst_n=0 for one cycle with winc=1: level=0, rempty=1, rvalid=0, ovf=0. With SYNC_FIFO_PEAK_EN, peak_level=0 after reset and reaches 16 after a refill.
